// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary CNN inference controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package bnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV1  = 3'd1,
        S_POOL1  = 3'd2,
        S_CONV2  = 3'd3,
        S_POOL2  = 3'd4,
        S_FC     = 3'd5,
        S_ARGMAX = 3'd6,
        S_OUT    = 3'd7
    } seq_state_t;

    // Bit positions in the one-hot stage enable
    localparam int STG_CONV1  = 0;
    localparam int STG_POOL1  = 1;
    localparam int STG_CONV2  = 2;
    localparam int STG_POOL2  = 3;
    localparam int STG_FC     = 4;
    localparam int STG_ARGMAX = 5;
    localparam int STAGE_N    = 6;

    // Default per-stage dwell times; pool1/pool2 use the same values for their
    // internal pipeline depth so the sequencer and datapath stay in step.
    localparam int DEF_CONV1_CYC  = 1;
    localparam int DEF_POOL1_CYC  = 2;
    localparam int DEF_CONV2_CYC  = 1;
    localparam int DEF_POOL2_CYC  = 2;
    localparam int DEF_FC_CYC     = 1;
    localparam int DEF_ARGMAX_CYC = 1;
    localparam int DEF_LAT_W      = 4;

endpackage

// File: rtl/stage_timer.sv
// Loadable down-counter that measures how long the sequencer dwells in a stage.
// Latency: load takes effect the next cycle; zero flag is a decode of the count.
// Backpressure: none; counts down every cycle and saturates at zero.
// Ports: clk/rst, load + load_val (load has priority over counting), value, zero.
module stage_timer #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] value,
    output logic             zero
);

    logic [LAT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Steps a one-hot stage enable through conv1..argmax for one image, then offers the class result.
// Latency: image fire at T -> stage_en[0] at T+1 -> class_out_valid at T+1+sum(*_CYC).
// Backpressure: class_out_valid holds until class_out_ready; images and weight writes are refused while busy.
// Ports: image_in_valid/ready + image_load, cfg_wr_valid/ready + cfg_wr_en, abort,
//        stage_en[5:0], class_capture, class_out_valid/ready, busy, inference_count[15:0].
module bnn_layer_sequencer
    import bnn_pkg::*;
#(
    parameter int CONV1_CYC  = DEF_CONV1_CYC,
    parameter int POOL1_CYC  = DEF_POOL1_CYC,
    parameter int CONV2_CYC  = DEF_CONV2_CYC,
    parameter int POOL2_CYC  = DEF_POOL2_CYC,
    parameter int FC_CYC     = DEF_FC_CYC,
    parameter int ARGMAX_CYC = DEF_ARGMAX_CYC,
    parameter int LAT_W      = DEF_LAT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               image_in_valid,
    output logic               image_in_ready,
    output logic               image_load,
    input  logic               cfg_wr_valid,
    output logic               cfg_wr_ready,
    output logic               cfg_wr_en,
    input  logic               abort,
    output logic [STAGE_N-1:0] stage_en,
    output logic               class_capture,
    input  logic               class_out_ready,
    output logic               class_out_valid,
    output logic               busy,
    output logic [15:0]        inference_count
);

    localparam int LAT_MAX = 2 ** LAT_W;

    if (CONV1_CYC < 1 || CONV1_CYC > LAT_MAX || POOL1_CYC < 1 || POOL1_CYC > LAT_MAX ||
        CONV2_CYC < 1 || CONV2_CYC > LAT_MAX || POOL2_CYC < 1 || POOL2_CYC > LAT_MAX ||
        FC_CYC < 1 || FC_CYC > LAT_MAX || ARGMAX_CYC < 1 || ARGMAX_CYC > LAT_MAX) begin : g_bad_cyc
        $error("bnn_layer_sequencer: every stage dwell must be in 1..2**LAT_W");
    end

    seq_state_t       state_q;
    seq_state_t       state_nxt;
    logic [15:0]      count_q;
    logic             tmr_load;
    logic [LAT_W-1:0] tmr_val;
    logic [LAT_W-1:0] tmr_value;
    logic             tmr_zero;
    logic             out_fire;

    // Timer reload value for the state being entered (dwell minus one).
    function automatic logic [LAT_W-1:0] cyc_m1(input seq_state_t s);
        case (s)
            S_CONV1:  cyc_m1 = LAT_W'(CONV1_CYC - 1);
            S_POOL1:  cyc_m1 = LAT_W'(POOL1_CYC - 1);
            S_CONV2:  cyc_m1 = LAT_W'(CONV2_CYC - 1);
            S_POOL2:  cyc_m1 = LAT_W'(POOL2_CYC - 1);
            S_FC:     cyc_m1 = LAT_W'(FC_CYC - 1);
            S_ARGMAX: cyc_m1 = LAT_W'(ARGMAX_CYC - 1);
            default:  cyc_m1 = '0;
        endcase
    endfunction

    stage_timer #(.LAT_W(LAT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt       = state_q;
        tmr_load        = 1'b0;
        image_in_ready  = 1'b0;
        image_load      = 1'b0;
        cfg_wr_ready    = 1'b0;
        cfg_wr_en       = 1'b0;
        stage_en        = '0;
        class_capture   = 1'b0;
        class_out_valid = 1'b0;
        busy            = (state_q != S_IDLE);
        out_fire        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cfg_wr_ready   = 1'b1;
                cfg_wr_en      = cfg_wr_valid;
                // A pending weight write takes the cycle; the image waits.
                image_in_ready = ~cfg_wr_valid;
                image_load     = image_in_valid & ~cfg_wr_valid;
                if (image_load) begin
                    state_nxt = S_CONV1;
                    tmr_load  = 1'b1;
                end
            end
            S_CONV1: begin
                stage_en[STG_CONV1] = 1'b1;
                if (tmr_zero) begin state_nxt = S_POOL1; tmr_load = 1'b1; end
            end
            S_POOL1: begin
                stage_en[STG_POOL1] = 1'b1;
                if (tmr_zero) begin state_nxt = S_CONV2; tmr_load = 1'b1; end
            end
            S_CONV2: begin
                stage_en[STG_CONV2] = 1'b1;
                if (tmr_zero) begin state_nxt = S_POOL2; tmr_load = 1'b1; end
            end
            S_POOL2: begin
                stage_en[STG_POOL2] = 1'b1;
                if (tmr_zero) begin state_nxt = S_FC; tmr_load = 1'b1; end
            end
            S_FC: begin
                stage_en[STG_FC] = 1'b1;
                if (tmr_zero) begin state_nxt = S_ARGMAX; tmr_load = 1'b1; end
            end
            S_ARGMAX: begin
                stage_en[STG_ARGMAX] = 1'b1;
                // Latch the result only on the last argmax cycle of a run that is not being cancelled.
                class_capture = (tmr_value == '0) & ~abort;
                if (tmr_zero) state_nxt = S_OUT;
            end
            S_OUT: begin
                class_out_valid = 1'b1;
                out_fire        = class_out_ready;
                if (class_out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Cancel wins over stage progress; an output handshake in the same cycle still counts.
        if (abort && state_q != S_IDLE) begin
            state_nxt = S_IDLE;
            tmr_load  = 1'b0;
        end

        tmr_val = cyc_m1(state_nxt);

        if (rst) begin
            image_in_ready  = 1'b0;
            image_load      = 1'b0;
            cfg_wr_ready    = 1'b0;
            cfg_wr_en       = 1'b0;
            stage_en        = '0;
            class_capture   = 1'b0;
            class_out_valid = 1'b0;
            busy            = 1'b0;
            out_fire        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (out_fire) count_q <= count_q + 16'd1;
        end
    end

    assign inference_count = count_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
module tb_bnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        image_in_valid;
    logic        image_in_ready;
    logic        image_load;
    logic        cfg_wr_valid;
    logic        cfg_wr_ready;
    logic        cfg_wr_en;
    logic        abort;
    logic [5:0]  stage_en;
    logic        class_capture;
    logic        class_out_ready;
    logic        class_out_valid;
    logic        busy;
    logic [15:0] inference_count;

    bnn_layer_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .image_in_valid  (image_in_valid),
        .image_in_ready  (image_in_ready),
        .image_load      (image_load),
        .cfg_wr_valid    (cfg_wr_valid),
        .cfg_wr_ready    (cfg_wr_ready),
        .cfg_wr_en       (cfg_wr_en),
        .abort           (abort),
        .stage_en        (stage_en),
        .class_capture   (class_capture),
        .class_out_ready (class_out_ready),
        .class_out_valid (class_out_valid),
        .busy            (busy),
        .inference_count (inference_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] m_count;
    logic [5:0]  sb_stage[$];
    logic [15:0] sb_count[$];
    // Expected stage_en per cycle with default dwells 1,2,1,2,1,1
    logic [5:0]  exp_seq [8] = '{6'h01, 6'h02, 6'h02, 6'h04, 6'h08, 6'h08, 6'h10, 6'h20};

    // Present an image in IDLE; on fire, queue the stage sequence it should produce.
    task automatic start_image();
        image_in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (image_load !== 1'b1) begin
            n_err++;
            $display("FAIL image_load: got %b want 1", image_load);
        end
        if (image_load === 1'b1)
            for (int i = 0; i < 8; i++) sb_stage.push_back(exp_seq[i]);
        @(posedge clk); #1;
        image_in_valid = 1'b0;
    endtask

    task automatic drain_stages(input bit cfg_hold);
        logic [5:0] exp;
        while (sb_stage.size() > 0) begin
            exp = sb_stage.pop_front();
            @(negedge clk);
            n_cmp++;
            if (stage_en !== exp) begin
                n_err++;
                $display("FAIL stage_en: got %h want %h", stage_en, exp);
            end
            n_cmp++;
            if (class_capture !== (exp == 6'h20)) begin
                n_err++;
                $display("FAIL class_capture: got %b want %b (stage %h)", class_capture, exp == 6'h20, exp);
            end
            n_cmp++;
            if (busy !== 1'b1 || image_in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_ready: got busy=%b img_rdy=%b want 1/0", busy, image_in_ready);
            end
            if (cfg_hold) begin
                n_cmp++;
                if (cfg_wr_ready !== 1'b0 || cfg_wr_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL cfg_blocked: got rdy=%b en=%b want 0/0", cfg_wr_ready, cfg_wr_en);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // In OUT: hold ready low for 'hold' cycles, then complete the handshake.
    task automatic out_handshake(input int hold);
        logic [15:0] exp;
        repeat (hold) begin
            @(negedge clk);
            n_cmp++;
            if (class_out_valid !== 1'b1 || stage_en !== 6'h00 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL out_hold: got vld=%b stg=%h busy=%b want 1/00/1", class_out_valid, stage_en, busy);
            end
            n_cmp++;
            if (cfg_wr_ready !== 1'b0 || cfg_wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL out_cfg: got rdy=%b en=%b want 0/0", cfg_wr_ready, cfg_wr_en);
            end
            @(posedge clk); #1;
        end
        class_out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (class_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL out_valid: got %b want 1", class_out_valid);
        end
        sb_count.push_back(m_count + 16'd1);
        m_count = m_count + 16'd1;
        @(posedge clk); #1;
        class_out_ready = 1'b0;
        @(negedge clk);
        exp = sb_count.pop_front();
        n_cmp++;
        if (inference_count !== exp) begin
            n_err++;
            $display("FAIL inference_count: got %h want %h", inference_count, exp);
        end
        n_cmp++;
        if (busy !== 1'b0 || class_out_valid !== 1'b0 || image_in_ready !== ~cfg_wr_valid ||
            cfg_wr_en !== cfg_wr_valid) begin
            n_err++;
            $display("FAIL back_to_idle: got busy=%b vld=%b img_rdy=%b cfg_en=%b want 0/0/%b/%b",
                     busy, class_out_valid, image_in_ready, cfg_wr_en, ~cfg_wr_valid, cfg_wr_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; image_in_valid = 1'b1; cfg_wr_valid = 1'b1; abort = 1'b0; class_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({image_in_ready, image_load, cfg_wr_ready, cfg_wr_en, stage_en, class_capture,
             class_out_valid, busy} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got ir=%b il=%b cr=%b ce=%b st=%h cc=%b ov=%b b=%b want all 0",
                     image_in_ready, image_load, cfg_wr_ready, cfg_wr_en, stage_en, class_capture,
                     class_out_valid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0; image_in_valid = 1'b0; cfg_wr_valid = 1'b0; class_out_ready = 1'b0;
        m_count = 16'd0;
        @(negedge clk);
        n_cmp++;
        if (image_in_ready !== 1'b1 || cfg_wr_ready !== 1'b1 || busy !== 1'b0 || inference_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_idle: got ir=%b cr=%b b=%b cnt=%h want 1/1/0/0000",
                     image_in_ready, cfg_wr_ready, busy, inference_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_inference();
        start_image();
        drain_stages(1'b0);
        out_handshake(0);
    endtask

    task automatic test_cfg_priority();
        cfg_wr_valid = 1'b1; image_in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cfg_wr_en !== 1'b1 || image_load !== 1'b0 || image_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_priority: got cfg_en=%b img_load=%b img_rdy=%b want 1/0/0",
                     cfg_wr_en, image_load, image_in_ready);
        end
        @(posedge clk); #1;
        cfg_wr_valid = 1'b0;
        start_image();
        drain_stages(1'b0);
        out_handshake(0);
    endtask

    task automatic test_cfg_blocked();
        start_image();
        cfg_wr_valid = 1'b1;
        drain_stages(1'b1);
        out_handshake(1);
        cfg_wr_valid = 1'b0;
    endtask

    task automatic test_out_backpressure();
        start_image();
        drain_stages(1'b0);
        out_handshake(5);
    endtask

    task automatic test_abort_pool1();
        start_image();
        @(negedge clk);
        n_cmp++;
        if (stage_en !== 6'h01) begin
            n_err++;
            $display("FAIL abort_pre_conv1: got %h want 01", stage_en);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (stage_en !== 6'h02) begin
            n_err++;
            $display("FAIL abort_pool1: got %h want 02", stage_en);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stage_en !== 6'h00 || busy !== 1'b0 || class_out_valid !== 1'b0 || inference_count !== m_count) begin
            n_err++;
            $display("FAIL abort_result: got stg=%h busy=%b vld=%b cnt=%h want 00/0/0/%h",
                     stage_en, busy, class_out_valid, inference_count, m_count);
        end
        sb_stage.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_abort_idle_and_out();
        // abort in IDLE must not block an image fire
        abort = 1'b1; image_in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (image_load !== 1'b1) begin
            n_err++;
            $display("FAIL abort_idle_fire: got %b want 1", image_load);
        end
        if (image_load === 1'b1)
            for (int i = 0; i < 8; i++) sb_stage.push_back(exp_seq[i]);
        @(posedge clk); #1;
        abort = 1'b0; image_in_valid = 1'b0;
        drain_stages(1'b0);
        // abort coincident with output handshake: count still increments
        abort = 1'b1; class_out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (class_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL abort_out_valid: got %b want 1", class_out_valid);
        end
        sb_count.push_back(m_count + 16'd1);
        m_count = m_count + 16'd1;
        @(posedge clk); #1;
        abort = 1'b0; class_out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (inference_count !== sb_count[0] || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_out_count: got cnt=%h busy=%b want %h/0", inference_count, busy, sb_count[0]);
        end
        sb_count.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_count_wrap();
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        m_count = 16'hFFFF;
        @(posedge clk); #1;
        start_image();
        drain_stages(1'b0);
        out_handshake(0);
    endtask

    initial begin
        test_reset();
        test_single_inference();
        test_cfg_priority();
        test_cfg_blocked();
        test_out_backpressure();
        test_abort_pool1();
        test_abort_idle_and_out();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
